// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX scheduling slice.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    function automatic int unsigned frame_bits(input int unsigned data_width);
        return data_width + 3;
    endfunction

    localparam int unsigned FRAME_BITS = frame_bits(DEFAULT_DATA_WIDTH);

    function automatic int unsigned cycles_per_bit(input int unsigned clk_freq,
                                                   input int unsigned baud);
        return clk_freq / baud;
    endfunction

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = |req;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = idx[IDX_W-1:0];
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among several byte producers,
// with a per-frame watchdog that recovers from a transmitter that never reports done.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned TIMEOUT_CYCLES =
        2 * cycles_per_bit(CLK_FREQ, BAUD_RATE) * frame_bits(DATA_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    gnt_onehot;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  any_req;
    logic                  accept;
    logic                  expire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    assign accept = (state_q == IDLE) && any_req;
    assign expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (any_req) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done || expire) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        if (accept) begin
            ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            tx_data_d = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            grant_d   = gnt_idx;
            busy_d    = 1'b1;
        end
        if (state_q == LAUNCH) begin
            wd_d = '0;
        end
        if (state_q == WAIT_DONE) begin
            wd_d = wd_q + WD_W'(1);
            if (tx_done || expire) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q     <= '0;
            wd_q      <= '0;
            tx_data_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
        end
    end

    // req_ready is gated by reset so producers never see an accept while held in reset.
    always_comb begin
        req_ready   = (reset_n && state_q == IDLE) ? gnt_onehot : '0;
        tx_start    = (state_q == LAUNCH);
        timeout_err = (state_q == WAIT_DONE) && expire && !tx_done;
        tx_data     = tx_data_q;
        grant_id    = grant_q;
        busy        = busy_q;
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: directed scenarios plus randomized traffic
// checked against a queue-free round-robin reference model.
module tb_uart_tx_scheduler;

    localparam int N       = 4;
    localparam int CPB     = 50_000_000 / 115_200;
    localparam int FRAME   = 11 * CPB;
    localparam int TIMEOUT = 2 * CPB * 11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  valid = 4'b0000;
    logic [7:0]  data [4];
    logic        tx_done = 1'b0;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int mptr     = 0;

    assign req_data = {data[3], data[2], data[1], data[0]};

    always #5 clk = ~clk;

    uart_tx_scheduler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: first valid requester at or after the pointer, wrapping.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One scheduling round from an IDLE cycle. delay = cycles from tx_start to tx_done;
    // delay 0 withholds tx_done so the watchdog must fire.
    task automatic run_frame(input int delay);
        int         w;
        int         limit;
        int         stray;
        logic [7:0] b;
        #1;
        w = pick(valid, mptr);
        chk("idle_ready", req_ready, (w < 0) ? 32'd0 : 32'(1 << w));
        chk("idle_busy", busy, 0);
        if (w < 0) begin
            tick();
            return;
        end
        b    = data[w];
        mptr = (w + 1) % N;
        tick();
        valid[w] = 1'b0;
        #1;
        chk("launch_start", tx_start, 1);
        chk("launch_data", tx_data, b);
        chk("launch_grant", grant_id, w);
        chk("launch_busy", busy, 1);
        chk("launch_ready", req_ready, 0);
        stray = 0;
        limit = (delay == 0) ? TIMEOUT : delay;
        for (int k = 1; k < limit; k++) begin
            tick();
            if (tx_start || timeout_err || req_ready != 0 || !busy) stray++;
        end
        tick();
        if (delay != 0) tx_done = 1'b1;
        #1;
        chk("wait_stray", stray, 0);
        chk("end_timeout_err", timeout_err, 32'(delay == 0));
        tick();
        tx_done = 1'b0;
        #1;
        chk("after_busy", busy, 0);
        chk("after_timeout_err", timeout_err, 0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < N; i++) data[i] = 8'h10 + 8'(i);
        valid = 4'b1111;

        // Reset values, with every requester already valid
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout_err, 0);
        reset_n = 1'b1;

        // All four valid out of reset: order 0,1,2,3
        for (int i = 0; i < N; i++) begin
            run_frame(20);
            chk("all4_grant", grant_id, i);
            chk("all4_byte", tx_data, 8'h10 + 8'(i));
        end

        // Fairness: 0 and 3 always valid alternate
        for (int i = 0; i < 4; i++) begin
            valid = 4'b1001;
            data[0] = 8'h40 + 8'(i);
            data[3] = 8'h70 + 8'(i);
            run_frame(10);
            chk("fair_grant", grant_id, (i % 2 == 1) ? 3 : 0);
        end

        // Single request from requester 2, full-length frame
        valid = 4'b0100;
        data[2] = 8'hA5;
        run_frame(FRAME);
        chk("single_data", tx_data, 8'hA5);
        chk("single_grant", grant_id, 2);

        // Watchdog expiry with requester 2 still pending behind requester 1
        valid = 4'b0110;
        data[1] = 8'h5A;
        data[2] = 8'hC3;
        run_frame(0);
        chk("to_next_ready", req_ready, 4'b0100);
        run_frame(12);
        chk("to_next_grant", grant_id, 2);

        // tx_done coincides with the expiry cycle
        valid = 4'b0001;
        data[0] = 8'h99;
        run_frame(TIMEOUT);

        // Asynchronous reset mid-frame
        valid = 4'b0010;
        data[1] = 8'h3C;
        #1;
        w = pick(valid, mptr);
        chk("mid_ready", req_ready, 32'(1 << w));
        tick();
        valid = 4'b0000;
        #1;
        chk("mid_start", tx_start, 1);
        repeat (5) tick();
        valid = 4'b1111;
        for (int i = 0; i < N; i++) data[i] = 8'hE0 + 8'(i);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_start", tx_start, 0);
        chk("mid_rst_data", tx_data, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        mptr = 0;
        tick();
        reset_n = 1'b1;
        run_frame(15);
        chk("post_rst_grant", grant_id, 0);

        // Randomized traffic against the reference model
        for (int it = 0; it < 16; it++) begin
            valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) data[i] = 8'($urandom);
            run_frame(int'($urandom_range(1, 30)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
